// File: rtl/idex_cond_stage.sv
// Decode->Execute pipeline register, NZCV condition unit and multi-cycle MUL/dot stall FSM.
// Optional perf counters are built when IDEX_PERF_EN is defined.
module idex_cond_stage #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned MULTI_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic [1:0]        FlagWriteD,
    input  logic              PCSrcD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              MemtoRegD,
    input  logic              ALUSrcD,
    input  logic              BranchD,
    input  logic [3:0]        ALUControlD,
    input  logic [3:0]        CondD,
    input  logic [WIDTH-1:0]  RD1D,
    input  logic [WIDTH-1:0]  RD2D,
    input  logic [WIDTH-1:0]  ExtImmD,
    input  logic [REG_AW-1:0] WA3D,
    input  logic [3:0]        ALUFlags,
    output logic [WIDTH-1:0]  RD1E,
    output logic [WIDTH-1:0]  RD2E,
    output logic [WIDTH-1:0]  ExtImmE,
    output logic [REG_AW-1:0] WA3E,
    output logic [3:0]        ALUControlE,
    output logic              ALUSrcE,
    output logic              MemtoRegE,
    output logic              PCSrcE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              BranchTakenE,
    output logic              CondExE,
    output logic [3:0]        FlagsE,
    output logic              BusyE,
    output logic [31:0]       RetiredCnt,
    output logic [31:0]       SquashCnt
);

    typedef enum logic {StIdle, StMulti} state_e;

    localparam int CntLoadInt = (MULTI_CYCLES > 1) ? int'(MULTI_CYCLES) - 2 : 0;
    localparam logic [3:0] CntLoad = 4'(CntLoadInt);

    logic              valid_q, pcsrc_q, regwrite_q, memwrite_q, memtoreg_q, alusrc_q, branch_q;
    logic [3:0]        alucontrol_q, cond_q, flags_q;
    logic [1:0]        flagwrite_q;
    logic [WIDTH-1:0]  rd1_q, rd2_q, imm_q;
    logic [REG_AW-1:0] wa3_q;
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              cond_ok, cond_ex, multi_entry, busy, enable;
    logic              n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ok = 1'b0;
        case (cond_q)
            4'b0000: cond_ok = z;
            4'b0001: cond_ok = !z;
            4'b0010: cond_ok = c;
            4'b0011: cond_ok = !c;
            4'b0100: cond_ok = n;
            4'b0101: cond_ok = !n;
            4'b0110: cond_ok = v;
            4'b0111: cond_ok = !v;
            4'b1000: cond_ok = c && !z;
            4'b1001: cond_ok = !c || z;
            4'b1010: cond_ok = (n == v);
            4'b1011: cond_ok = (n != v);
            4'b1100: cond_ok = !z && (n == v);
            4'b1101: cond_ok = z || (n != v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign cond_ex     = valid_q && cond_ok;
    assign multi_entry = cond_ex && (alucontrol_q == 4'b0110 || alucontrol_q == 4'b0001) &&
                         (MULTI_CYCLES > 1) && !StallE && !FlushE;
    assign enable      = cond_ex && !busy && !StallE;

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            valid_q      <= 1'b0;
            pcsrc_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            alusrc_q     <= 1'b0;
            branch_q     <= 1'b0;
            alucontrol_q <= '0;
            cond_q       <= '0;
            flagwrite_q  <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            wa3_q        <= '0;
        end else if (!(StallE || busy)) begin
            valid_q      <= 1'b1;
            pcsrc_q      <= PCSrcD;
            regwrite_q   <= RegWriteD;
            memwrite_q   <= MemWriteD;
            memtoreg_q   <= MemtoRegD;
            alusrc_q     <= ALUSrcD;
            branch_q     <= BranchD;
            alucontrol_q <= ALUControlD;
            cond_q       <= CondD;
            flagwrite_q  <= FlagWriteD;
            rd1_q        <= RD1D;
            rd2_q        <= RD2D;
            imm_q        <= ExtImmD;
            wa3_q        <= WA3D;
        end
    end

    // Flags commit at the edge that ends the instruction's last E cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (enable) begin
            if (flagwrite_q[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (flagwrite_q[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (FlushE) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (!StallE) begin
            unique case (state_q)
                StIdle: begin
                    if (multi_entry) begin
                        state_d = StMulti;
                        cnt_d   = CntLoad;
                    end
                end
                StMulti: begin
                    if (cnt_q == 4'd0) state_d = StIdle;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            StIdle:  busy = multi_entry;
            StMulti: busy = (cnt_q != 4'd0);
        endcase
    end

    assign RD1E         = rd1_q;
    assign RD2E         = rd2_q;
    assign ExtImmE      = imm_q;
    assign WA3E         = wa3_q;
    assign ALUControlE  = alucontrol_q;
    assign ALUSrcE      = alusrc_q;
    assign MemtoRegE    = memtoreg_q;
    assign PCSrcE       = pcsrc_q && enable;
    assign RegWriteE    = regwrite_q && enable;
    assign MemWriteE    = memwrite_q && enable;
    assign BranchTakenE = branch_q && enable;
    assign CondExE      = cond_ex;
    assign FlagsE       = flags_q;
    assign BusyE        = busy;

`ifdef IDEX_PERF_EN
    logic [31:0] retired_q, squash_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            squash_q  <= '0;
        end else begin
            if (enable)                          retired_q <= retired_q + 32'd1;
            if (valid_q && !cond_ok && !StallE) squash_q  <= squash_q + 32'd1;
        end
    end

    assign RetiredCnt = retired_q;
    assign SquashCnt  = squash_q;
`else
    assign RetiredCnt = '0;
    assign SquashCnt  = '0;
`endif

endmodule

// File: tb/tb_idex_cond_stage.sv
// Randomized + directed bench for idex_cond_stage against a cycle-level behavioural model.
module tb_idex_cond_stage;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int MC = 4;

    logic          clk = 1'b0;
    logic          reset, StallE, FlushE;
    logic [1:0]    FlagWriteD;
    logic          PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD;
    logic [3:0]    ALUControlD, CondD, ALUFlags;
    logic [W-1:0]  RD1D, RD2D, ExtImmD;
    logic [AW-1:0] WA3D;
    logic [W-1:0]  RD1E, RD2E, ExtImmE;
    logic [AW-1:0] WA3E;
    logic [3:0]    ALUControlE, FlagsE;
    logic          ALUSrcE, MemtoRegE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE, CondExE, BusyE;
    logic [31:0]   RetiredCnt, SquashCnt;

    idex_cond_stage #(.WIDTH(W), .REG_AW(AW), .MULTI_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .FlagWriteD(FlagWriteD),
        .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
        .ALUSrcD(ALUSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD), .CondD(CondD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .WA3D(WA3D), .ALUFlags(ALUFlags),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .WA3E(WA3E), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .BranchTakenE(BranchTakenE), .CondExE(CondExE), .FlagsE(FlagsE),
        .BusyE(BusyE), .RetiredCnt(RetiredCnt), .SquashCnt(SquashCnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: contents of E, flags, and how many unstalled cycles the op has spent in E.
    logic          m_valid, m_pc, m_rw, m_mw, m_m2r, m_as, m_br;
    logic [3:0]    m_alu, m_cond;
    logic [1:0]    m_fw;
    logic [W-1:0]  m_rd1, m_rd2, m_imm;
    logic [AW-1:0] m_wa3;
    logic          m_n, m_z, m_c, m_v;
    int            m_age;
    logic [31:0]   m_ret, m_sq;
    logic          e_ok, e_cex, e_busy, e_en;

    function automatic logic cond_holds(input logic [3:0] cc, input logic n, z, c, v);
        case (cc)
            0: return z;              1: return !z;
            2: return c;              3: return !c;
            4: return n;              5: return !n;
            6: return v;              7: return !v;
            8: return c && !z;        9: return !c || z;
            10: return n == v;        11: return n != v;
            12: return !z && n == v;  13: return z || n != v;
            14: return 1'b1;          default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear_e();
        {m_valid, m_pc, m_rw, m_mw, m_m2r, m_as, m_br} = '0;
        m_alu = '0; m_cond = '0; m_fw = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_wa3 = '0;
        m_age = 0;
    endtask

    task automatic model_eval();
        logic is_long;
        e_ok    = cond_holds(m_cond, m_n, m_z, m_c, m_v);
        e_cex   = m_valid && e_ok;
        is_long = (m_alu == 4'b0110 || m_alu == 4'b0001) && MC > 1;
        if (m_age == 0) e_busy = e_cex && is_long && !StallE && !FlushE;
        else            e_busy = e_cex && is_long && (m_age < MC - 1);
        e_en = e_cex && !e_busy && !StallE;
    endtask

    task automatic model_update();
        if (reset) begin
            model_clear_e();
            {m_n, m_z, m_c, m_v} = '0;
            m_ret = '0; m_sq = '0;
            return;
        end
        if (e_en) begin
            m_ret++;
            if (m_fw[1]) begin m_n = ALUFlags[3]; m_z = ALUFlags[2]; end
            if (m_fw[0]) begin m_c = ALUFlags[1]; m_v = ALUFlags[0]; end
        end
        if (m_valid && !e_ok && !StallE) m_sq++;
        if (FlushE) begin
            model_clear_e();
        end else if (StallE || e_busy) begin
            if (!StallE) m_age++;
        end else begin
            m_valid = 1'b1; m_pc = PCSrcD; m_rw = RegWriteD; m_mw = MemWriteD;
            m_m2r = MemtoRegD; m_as = ALUSrcD; m_br = BranchD; m_alu = ALUControlD;
            m_cond = CondD; m_fw = FlagWriteD; m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ExtImmD;
            m_wa3 = WA3D; m_age = 0;
        end
    endtask

    // Compare every output against the model mid-cycle, then advance one clock.
    task automatic cycle();
        logic [63:0] exp_perf;
        @(negedge clk);
        model_eval();
        check_val("ctl", {RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE, BusyE},
                  {m_rw && e_en, m_mw && e_en, m_pc && e_en, m_br && e_en, e_cex, e_busy});
        check_val("regctl", {ALUControlE, ALUSrcE, MemtoRegE}, {m_alu, m_as, m_m2r});
        check_val("flags", FlagsE, {m_n, m_z, m_c, m_v});
        check_val("ops", {RD1E, RD2E, ExtImmE, WA3E}, {m_rd1, m_rd2, m_imm, m_wa3});
`ifdef IDEX_PERF_EN
        exp_perf = {m_ret, m_sq};
`else
        exp_perf = '0;
`endif
        check_val("perf", {RetiredCnt, SquashCnt}, exp_perf);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic instr(input logic [3:0] alu, input logic [3:0] cc, input logic [1:0] fw,
                         input logic rw, input logic pc, input logic br, input logic [AW-1:0] wa);
        ALUControlD = alu; CondD = cc; FlagWriteD = fw; RegWriteD = rw; PCSrcD = pc;
        BranchD = br; WA3D = wa; MemWriteD = 1'b0; MemtoRegD = 1'b0; ALUSrcD = 1'b0;
        RD1D = $urandom; RD2D = $urandom; ExtImmD = $urandom;
        StallE = 1'b0; FlushE = 1'b0;
    endtask

    task automatic bubble();
        instr(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic rand_inputs();
        ALUControlD = ($urandom_range(0, 2) == 0) ? ($urandom_range(0, 1) ? 4'b0110 : 4'b0001)
                                                   : 4'($urandom);
        CondD = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom);
        FlagWriteD = 2'($urandom);
        {PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD} = 6'($urandom);
        RD1D = $urandom; RD2D = $urandom; ExtImmD = $urandom; WA3D = AW'($urandom);
        ALUFlags = 4'($urandom);
        StallE = ($urandom_range(0, 9) == 0);
        FlushE = ($urandom_range(0, 19) == 0);
        reset  = ($urandom_range(0, 299) == 0);
    endtask

    int busy_cycles;
    logic [63:0] exp_cnt;

    initial begin
        reset = 1'b1; ALUFlags = 4'b0100;
        bubble();
        #1;
        cycle();
        reset = 1'b0;
        #2;
        check_val("rst_regwrite", RegWriteE, 1'b0);
        check_val("rst_flags", FlagsE, 4'b0000);
        check_val("rst_busy", BusyE, 1'b0);
        cycle();

        // ADD, AL, writes all flags
        instr(4'b0100, 4'b1110, 2'b11, 1'b1, 1'b0, 1'b0, 5'd1);
        cycle();
        bubble();
        #2;
        check_val("add_regwrite", RegWriteE, 1'b1);
        check_val("add_condex", CondExE, 1'b1);
        cycle();
        #2;
        check_val("add_flags", FlagsE, 4'b0100);

        // NE branch with Z=1 fails, EQ branch is taken
        instr(4'b0100, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b1, '0);
        cycle();
        bubble();
        #2;
        check_val("ne_pcsrc", PCSrcE, 1'b0);
        check_val("ne_taken", BranchTakenE, 1'b0);
        cycle();
        #2;
        check_val("ne_flags", FlagsE, 4'b0100);
        instr(4'b0100, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, '0);
        cycle();
        bubble();
        #2;
        check_val("eq_taken", BranchTakenE, 1'b1);
        check_val("eq_pcsrc", PCSrcE, 1'b1);
        cycle();

        // MUL occupies E for MC cycles
        instr(4'b0110, 4'b1110, 2'b00, 1'b1, 1'b0, 1'b0, 5'd2);
        cycle();
        instr(4'b0100, 4'b1110, 2'b00, 1'b1, 1'b0, 1'b0, 5'd7);
        for (int i = 0; i < MC - 1; i++) begin
            #2;
            check_val("mul_busy", BusyE, 1'b1);
            check_val("mul_regwrite_hold", RegWriteE, 1'b0);
            check_val("mul_hold_op", ALUControlE, 4'b0110);
            cycle();
        end
        #2;
        check_val("mul_done_busy", BusyE, 1'b0);
        check_val("mul_done_regwrite", RegWriteE, 1'b1);
        cycle();
        #2;
        check_val("mul_next_op", {ALUControlE, WA3E}, {4'b0100, 5'd7});
        bubble();
        cycle();

        // MUL aborted by a flush in its second cycle
        ALUFlags = 4'b1011;
        instr(4'b0110, 4'b1110, 2'b11, 1'b1, 1'b0, 1'b0, 5'd4);
        cycle();
        bubble();
        #2;
        check_val("fl_busy1", BusyE, 1'b1);
        cycle();
        FlushE = 1'b1;
        #2;
        check_val("fl_busy2", BusyE, 1'b1);
        cycle();
        FlushE = 1'b0;
        #2;
        check_val("fl_ctl", {RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE, BusyE}, 6'b0);
        check_val("fl_flags", FlagsE, 4'b0100);
        cycle();
        ALUFlags = 4'b0100;

        // StallE for two cycles during MULTI stretches busy to 5 cycles
        instr(4'b0110, 4'b1110, 2'b00, 1'b1, 1'b0, 1'b0, 5'd3);
        cycle();
        instr(4'b0100, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9);
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            StallE = (i == 1 || i == 2);
            WA3D = (i == 1 || i == 2) ? 5'd11 : 5'd9;
            #2;
            if (BusyE) busy_cycles++;
            if (i == 3) check_val("stall_wa3_held", WA3E, 5'd3);
            cycle();
        end
        check_val("stall_busy_cycles", busy_cycles, 5);
        check_val("stall_next_wa3", WA3E, 5'd9);

        // perf: 3 retired, 2 squashed
        reset = 1'b1;
        bubble();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            instr(4'b0100, (i < 3) ? 4'b1110 : 4'b1111, 2'b00, 1'b1, 1'b0, 1'b0, 5'd5);
            cycle();
        end
        bubble();
        FlushE = 1'b1;
        cycle();
        FlushE = 1'b0;
        #2;
`ifdef IDEX_PERF_EN
        exp_cnt = {32'd3, 32'd2};
`else
        exp_cnt = '0;
`endif
        check_val("perf_counts", {RetiredCnt, SquashCnt}, exp_cnt);
        cycle();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/idex_cond_stage.md
Name: idex_cond_stage

Overview:
- Decode→Execute pipeline register plus Execute-stage condition unit for the pipelined vector CPU.
- Captures the decoder's control bundle and operands, evaluates the 4-bit condition against the architectural NZCV flags register, and gates side effects.
- Owns the flags register.
- Stalls the pipeline for multi-cycle ALU ops: MUL (ALUControl 0110) and dot product (0001).

Parameters:
- WIDTH, 32, datapath width of RD1/RD2/ExtImm.
- REG_AW, 5, register address width (matches 5-bit Rd).
- MULTI_CYCLES, 4, total Execute-stage cycles for MUL/dot product; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- StallE  in  1  hold E register and FSM (hazard unit).
- FlushE  in  1  replace E contents with bubble (hazard unit).
- FlagWriteD  in  2  [1]=update N,Z; [0]=update C,V.
- PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD  in  1 each  decoder controls.
- ALUControlD  in  4  ALU op.
- CondD  in  4  instruction condition field.
- RD1D, RD2D, ExtImmD  in  WIDTH each  operands.
- WA3D  in  REG_AW  destination register.
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the op currently in E.
- RD1E, RD2E, ExtImmE  out  WIDTH  registered operands.
- WA3E  out  REG_AW  registered destination.
- ALUControlE  out  4; ALUSrcE, MemtoRegE  out  1  registered controls.
- PCSrcE, RegWriteE, MemWriteE, BranchTakenE  out  1 each  condition- and busy-gated controls.
- CondExE  out  1  condition passed and instruction valid.
- FlagsE  out  4  current NZCV register.
- BusyE  out  1  multi-cycle stall request to F/D and hazard unit.
- RetiredCnt, SquashCnt  out  32 each  perf counters (see Optional Feature).

Behaviour:
- Reset: all E registers cleared (bubble: every control 0, operands 0, ValidE=0), FlagsE=0000, FSM=IDLE, BusyE=0. All outputs read 0.
- E register update priority: reset > FlushE (bubble, ValidE=0, FSM→IDLE, counter cleared) > StallE or BusyE (hold) > load D inputs with ValidE=1. Latency 1 cycle D→E.
- Condition codes, evaluated on FlagsE:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C;
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V;
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V;
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never (0).
- CondExE = ValidE & condition.
- Enable = CondExE & !BusyE & !StallE.
  - RegWriteE = RegWriteE_reg & Enable; MemWriteE likewise; PCSrcE likewise.
  - BranchTakenE = BranchE_reg & Enable.
- Flags update at the clock edge when Enable:
  - FlagWriteE[1] loads N,Z from ALUFlags.
  - FlagWriteE[0] loads C,V.
  - Both bits set: all four load together.
  - Condition-failed instructions never update flags.
  - The next instruction in E sees the new flags; no forwarding path needed.
- Multi-cycle FSM, states IDLE and MULTI:
  - IDLE→MULTI when CondExE & ALUControlE∈{0110,0001} & MULTI_CYCLES>1 & !StallE & !FlushE. Counter loads MULTI_CYCLES-2.
  - BusyE = (state==IDLE & that entry condition) | (state==MULTI & counter!=0).
  - In MULTI, counter decrements each unstalled cycle. At counter==0, BusyE=0 and the instruction completes (Enable may assert); the FSM returns to IDLE on that edge.
  - Net result: the op occupies E exactly MULTI_CYCLES cycles with BusyE high for the first MULTI_CYCLES-1.
  - StallE freezes the counter and state.
  - FlushE mid-operation aborts: bubble, IDLE, BusyE=0 next cycle, no flag/reg update.
  - Condition-failed MUL does not enter MULTI (single cycle, squashed).
  - MULTI_CYCLES=1: FSM never leaves IDLE.
- Simultaneous StallE and FlushE: flush wins.

Optional Feature:
- Macro IDEX_PERF_EN.
- Defined:
  - RetiredCnt increments on each cycle with Enable=1.
  - SquashCnt increments on each cycle where ValidE & !condition & !StallE.
  - Both wrap at 2^32 and clear on reset; FlushE does not clear them.
- Undefined: RetiredCnt and SquashCnt are constant 0 and no counter logic is built.

Test Plan:
- Reset then ADD with FlagWriteD=11, CondD=1110, ALUFlags=0100 → next cycle RegWriteE=1, CondExE=1; cycle after, FlagsE=0100.
- FlagsE Z=1, branch with CondD=0001 (NE), PCSrcD=BranchD=1 → PCSrcE=0, BranchTakenE=0, FlagsE unchanged; with CondD=0000, BranchTakenE=1.
- MUL (ALUControlD=0110, AL, RegWriteD=1), MULTI_CYCLES=4 → BusyE=1 for 3 cycles with RegWriteE=0, E held; 4th cycle BusyE=0 and RegWriteE=1; next instruction enters E on cycle 5.
- MUL busy, FlushE pulse on 2nd cycle → next cycle all controls 0, BusyE=0, FlagsE unchanged.
- StallE=1 for 2 cycles during MULTI → total busy extends to 5 cycles; D inputs changed during stall are not captured.
- IDEX_PERF_EN defined: 3 AL instructions and 2 condition-failed instructions → RetiredCnt=3, SquashCnt=2; without macro, both 0.
